// File: rtl/psum_drain_accum.sv
// psum_drain_accum: drains OFIFO psum vectors, optionally combines them with
// psum memory contents per lane, and writes results back sequentially.
module psum_drain_accum #(
  parameter int col     = 8,
  parameter int psum_bw = 32,
  parameter int addr_bw = 11,
  parameter int mem_lat = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [addr_bw-1:0]       base_addr,
  input  logic [addr_bw-1:0]       num_vec,
  input  logic [1:0]               mode,
  input  logic                     ofifo_valid,
  output logic                     ofifo_rd,
  input  logic [psum_bw*col-1:0]   ofifo_out,
  output logic                     mem_rd,
  output logic [addr_bw-1:0]       mem_rd_addr,
  input  logic [psum_bw*col-1:0]   mem_rd_data,
  output logic                     mem_wr,
  output logic [addr_bw-1:0]       mem_wr_addr,
  output logic [psum_bw*col-1:0]   mem_wr_data,
  output logic                     busy,
  output logic                     done,
  output logic [col-1:0]           sat_flag
);

  localparam int w = psum_bw * col;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [addr_bw-1:0] base_q;
  logic [addr_bw-1:0] num_q;
  logic [addr_bw-1:0] issued;
  logic [addr_bw-1:0] rd_addr_q;
  logic [addr_bw-1:0] issue_addr;
  logic [1:0]         mode_q;
  logic [addr_bw:0]   inflight;
  logic               acc;
  logic               issue;
  logic               accept;

  assign acc        = (mode_q == 2'b01) || (mode_q == 2'b10);
  assign accept     = (state == IDLE) && start;
  assign issue_addr = base_q + issued;

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (num_vec == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (ofifo_valid) begin
          issue = 1'b1;
          if (issued + addr_bw'(1) == num_q)
            state_nx = FLUSH;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        // leave as soon as the final write is on the bus
        if (inflight == (addr_bw+1)'(mem_wr))
          state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ofifo_rd    = issue;
  assign mem_rd      = issue & acc;
  assign mem_rd_addr = mem_rd ? issue_addr : rd_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      base_q    <= '0;
      num_q     <= '0;
      issued    <= '0;
      mode_q    <= '0;
      rd_addr_q <= '0;
      inflight  <= '0;
    end else begin
      state    <= state_nx;
      inflight <= inflight + (addr_bw+1)'(issue)
                  - (addr_bw+1)'(mem_wr);
      if (accept) begin
        base_q <= base_addr;
        num_q  <= num_vec;
        mode_q <= mode;
        issued <= '0;
      end else if (issue) begin
        issued <= issued + addr_bw'(1);
      end
      if (mem_rd)
        rd_addr_q <= issue_addr;
    end
  end

  logic [mem_lat-1:0] sv;
  logic [addr_bw-1:0] sa [mem_lat];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sv <= '0;
      for (int k = 0; k < mem_lat; k++)
        sa[k] <= '0;
    end else begin
      sv[0] <= issue;
      sa[0] <= issue_addr;
      for (int k = 1; k < mem_lat; k++) begin
        sv[k] <= sv[k-1];
        sa[k] <= sa[k-1];
      end
    end
  end

  logic [w-1:0] fifo_al;

  // OFIFO data arrives one cycle after issue; stretch it to meet read data
  if (mem_lat > 1) begin : g_dly
    logic [w-1:0] fd [mem_lat-1];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < mem_lat-1; k++)
          fd[k] <= '0;
      end else begin
        fd[0] <= ofifo_out;
        for (int k = 1; k < mem_lat-1; k++)
          fd[k] <= fd[k-1];
      end
    end
    assign fifo_al = fd[mem_lat-2];
  end else begin : g_nodly
    assign fifo_al = ofifo_out;
  end

  logic [w-1:0]   comb_data;
  logic [col-1:0] comb_sat;

  for (genvar l = 0; l < col; l++) begin : g_lane
    logic [psum_bw-1:0] f, m, a, r;
    logic [psum_bw:0]   s;
    logic               ovf;

    assign f   = fifo_al[l*psum_bw +: psum_bw];
    assign m   = mem_rd_data[l*psum_bw +: psum_bw];
    assign s   = {f[psum_bw-1], f} + {m[psum_bw-1], m};
    assign ovf = s[psum_bw] ^ s[psum_bw-1];
    assign a   = ovf ? {s[psum_bw], {(psum_bw-1){~s[psum_bw]}}}
                     : s[psum_bw-1:0];

    always_comb begin
      r = f;
      unique case (mode_q)
        2'b01:   r = a;
        2'b10:   r = a[psum_bw-1] ? '0 : a;
        2'b11:   r = f[psum_bw-1] ? '0 : f;
        default: r = f;
      endcase
    end

    assign comb_data[l*psum_bw +: psum_bw] = r;
    assign comb_sat[l] = ovf & acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_wr      <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      sat_flag    <= '0;
    end else begin
      mem_wr <= sv[mem_lat-1];
      if (sv[mem_lat-1]) begin
        mem_wr_addr <= sa[mem_lat-1];
        mem_wr_data <= comb_data;
        sat_flag    <= sat_flag | comb_sat;
      end
      if (accept)
        sat_flag <= '0;
    end
  end

endmodule

// File: tb/tb_psum_drain_accum.sv
// Bench for psum_drain_accum: OFIFO and psum memory models plus an
// arithmetic reference of each pass, compared against recorded DUT traffic.
module tb_psum_drain_accum;

  localparam int COL   = 4;
  localparam int PBW   = 32;
  localparam int ABW   = 4;
  localparam int LAT   = 3;
  localparam int W     = COL * PBW;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [ABW-1:0] base_addr = '0;
  logic [ABW-1:0] num_vec = '0;
  logic [1:0]     mode = '0;
  logic           ofifo_valid;
  logic           ofifo_rd;
  logic [W-1:0]   ofifo_out = '0;
  logic           mem_rd;
  logic [ABW-1:0] mem_rd_addr;
  logic [W-1:0]   mem_rd_data;
  logic           mem_wr;
  logic [ABW-1:0] mem_wr_addr;
  logic [W-1:0]   mem_wr_data;
  logic           busy;
  logic           done;
  logic [COL-1:0] sat_flag;

  always #5 clk = ~clk;

  psum_drain_accum #(
    .col(COL), .psum_bw(PBW), .addr_bw(ABW), .mem_lat(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .num_vec(num_vec), .mode(mode),
    .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd),
    .ofifo_out(ofifo_out), .mem_rd(mem_rd),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr(mem_wr), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .busy(busy), .done(done),
    .sat_flag(sat_flag)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // psum memory with LAT-cycle read latency
  logic [W-1:0] mem     [DEPTH];
  logic [W-1:0] pre_mem [DEPTH];
  logic [W-1:0] rd_pipe [LAT];
  logic         load_mem = 1'b0;

  assign mem_rd_data = rd_pipe[LAT-1];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= pre_mem[a];
    end else if (mem_wr) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
    rd_pipe[0] <= mem_rd ? mem[mem_rd_addr] : '0;
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  // OFIFO: data appears the cycle after a pop
  logic [W-1:0] farr [256];
  int           fwr = 0;
  int           frd = 0;
  logic         gate = 1'b1;

  assign ofifo_valid = gate && (fwr != frd);

  always @(posedge clk) begin
    if (reset) begin
      frd <= fwr;
    end else if (ofifo_rd) begin
      ofifo_out <= farr[frd % 256];
      frd <= frd + 1;
    end
  end

  int             rd_cyc [$];
  int             mrd_cyc [$];
  int             wr_cyc [$];
  int             done_cyc [$];
  logic [ABW-1:0] mrd_addr [$];
  logic [ABW-1:0] wr_addr [$];
  logic [W-1:0]   wr_data [$];

  always @(negedge clk) begin
    if (!reset) begin
      if (ofifo_rd) rd_cyc.push_back(cyc);
      if (mem_rd) begin
        mrd_cyc.push_back(cyc);
        mrd_addr.push_back(mem_rd_addr);
      end
      if (mem_wr) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(mem_wr_addr);
        wr_data.push_back(mem_wr_data);
      end
      if (done) done_cyc.push_back(cyc);
    end
  end

  logic [W-1:0] vecs [$];

  function automatic logic [PBW-1:0] ref_lane(
    input logic [PBW-1:0] f, input logic [PBW-1:0] m,
    input logic [1:0] md, output bit sat);
    longint fi = $signed(f);
    longint mi = $signed(m);
    longint mx = (64'sd1 <<< (PBW-1)) - 1;
    longint mn = -(64'sd1 <<< (PBW-1));
    longint s = fi + mi;
    longint r;
    bit     c = 0;
    if (s > mx) begin s = mx; c = 1; end
    else if (s < mn) begin s = mn; c = 1; end
    case (md)
      2'd0: r = fi;
      2'd1: r = s;
      2'd2: r = (s < 0) ? 0 : s;
      default: r = (fi < 0) ? 0 : fi;
    endcase
    sat = c && (md == 2'd1 || md == 2'd2);
    return r[PBW-1:0];
  endfunction

  function automatic logic [PBW-1:0] rand_lane();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'h7FFF_FF00 + $urandom_range(0, 255);
      2: return 32'h8000_0100 - $urandom_range(0, 511);
      default: return $urandom_range(0, 2000) - 1000;
    endcase
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int l = 0; l < COL; l++) v[l*PBW +: PBW] = rand_lane();
    return v;
  endfunction

  task automatic load_memory();
    @(posedge clk); #1; load_mem = 1'b1;
    @(posedge clk); #1; load_mem = 1'b0;
  endtask

  task automatic clear_mon();
    rd_cyc.delete(); mrd_cyc.delete(); mrd_addr.delete();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    done_cyc.delete();
  endtask

  task automatic run_pass(input logic [ABW-1:0] b, input int n,
                          input logic [1:0] m, input logic [15:0] pat,
                          input string tag);
    logic [W-1:0]   exp_d [$];
    logic [COL-1:0] exp_sat = '0;
    int             rel [$];
    int             t0;
    int             nrd;
    bit             acc = (m == 2'd1) || (m == 2'd2);
    for (int k = 0; k < n; k++) begin
      logic [ABW-1:0] a = b + ABW'(k);
      logic [W-1:0]   v = vecs[k];
      logic [W-1:0]   mm = pre_mem[a];
      logic [W-1:0]   e;
      for (int l = 0; l < COL; l++) begin
        bit s;
        e[l*PBW +: PBW] = ref_lane(v[l*PBW +: PBW], mm[l*PBW +: PBW], m, s);
        if (s) exp_sat[l] = 1'b1;
      end
      exp_d.push_back(e);
    end
    for (int i = 1; rel.size() < n && i < 400; i++)
      if (pat[i % 16]) rel.push_back(i);
    clear_mon();
    for (int k = 0; k < n; k++) begin
      farr[fwr % 256] = vecs[k];
      fwr++;
    end
    @(posedge clk); #1;
    base_addr = b; num_vec = ABW'(n); mode = m;
    start = 1'b1; gate = pat[0]; t0 = cyc;
    for (int i = 1; i < 300; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      gate = pat[i % 16];
      if (i == 1) begin
        @(negedge clk);
        checks++;
        if (sat_flag !== '0) begin
          errors++;
          $display("FAIL %s sat_clear got %b exp 0", tag, sat_flag);
        end
      end
      if (done_cyc.size() > 0) break;
    end
    checks++;
    if (done_cyc.size() == 0) begin
      errors++;
      $display("FAIL %s done_timeout got none exp 1 pulse", tag);
    end
    repeat (LAT + 3) @(posedge clk);
    #1; gate = 1'b1;

    checks++;
    if (wr_addr.size() != n) begin
      errors++;
      $display("FAIL %s wr_count got %0d exp %0d", tag, wr_addr.size(), n);
    end
    for (int k = 0; k < n && k < wr_addr.size(); k++) begin
      logic [ABW-1:0] ea = b + ABW'(k);
      checks += 3;
      if (wr_addr[k] !== ea) begin
        errors++;
        $display("FAIL %s wr_addr[%0d] got %0d exp %0d", tag, k, wr_addr[k], ea);
      end
      if (wr_data[k] !== exp_d[k]) begin
        errors++;
        $display("FAIL %s wr_data[%0d] got %h exp %h", tag, k, wr_data[k], exp_d[k]);
      end
      if (wr_cyc[k] != t0 + rel[k] + LAT + 1) begin
        errors++;
        $display("FAIL %s wr_cyc[%0d] got %0d exp %0d", tag, k,
                 wr_cyc[k] - t0, rel[k] + LAT + 1);
      end
    end
    checks++;
    if (rd_cyc.size() != n) begin
      errors++;
      $display("FAIL %s ofifo_rd_count got %0d exp %0d", tag, rd_cyc.size(), n);
    end
    for (int k = 0; k < n && k < rd_cyc.size(); k++) begin
      checks++;
      if (rd_cyc[k] != t0 + rel[k]) begin
        errors++;
        $display("FAIL %s ofifo_rd_cyc[%0d] got %0d exp %0d", tag, k,
                 rd_cyc[k] - t0, rel[k]);
      end
    end
    nrd = acc ? n : 0;
    checks++;
    if (mrd_cyc.size() != nrd) begin
      errors++;
      $display("FAIL %s mem_rd_count got %0d exp %0d", tag, mrd_cyc.size(), nrd);
    end
    for (int k = 0; k < nrd && k < mrd_cyc.size(); k++) begin
      logic [ABW-1:0] ea = b + ABW'(k);
      checks += 2;
      if (mrd_addr[k] !== ea) begin
        errors++;
        $display("FAIL %s mem_rd_addr[%0d] got %0d exp %0d", tag, k, mrd_addr[k], ea);
      end
      if (mrd_cyc[k] != t0 + rel[k]) begin
        errors++;
        $display("FAIL %s mem_rd_cyc[%0d] got %0d exp %0d", tag, k,
                 mrd_cyc[k] - t0, rel[k]);
      end
    end
    checks++;
    if (done_cyc.size() != 1) begin
      errors++;
      $display("FAIL %s done_count got %0d exp 1", tag, done_cyc.size());
    end else if (n > 0) begin
      checks++;
      if (done_cyc[0] != t0 + rel[n-1] + LAT + 2) begin
        errors++;
        $display("FAIL %s done_cyc got %0d exp %0d", tag,
                 done_cyc[0] - t0, rel[n-1] + LAT + 2);
      end
    end else begin
      checks++;
      if (done_cyc[0] < t0 + 1 || done_cyc[0] > t0 + 2) begin
        errors++;
        $display("FAIL %s empty_done_cyc got %0d exp 1..2", tag, done_cyc[0] - t0);
      end
    end
    checks += 2;
    if (sat_flag !== exp_sat) begin
      errors++;
      $display("FAIL %s sat_flag got %b exp %b", tag, sat_flag, exp_sat);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after got %b exp 0", tag, busy);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    checks += 3;
    if ({ofifo_rd, mem_rd, mem_wr, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL %s ctrl got %b exp 00000", tag,
               {ofifo_rd, mem_rd, mem_wr, busy, done});
    end
    if ({mem_rd_addr, mem_wr_addr, sat_flag} !== '0) begin
      errors++;
      $display("FAIL %s addr_sat got %h/%h/%b exp 0", tag,
               mem_rd_addr, mem_wr_addr, sat_flag);
    end
    if (mem_wr_data !== '0) begin
      errors++;
      $display("FAIL %s wr_data got %h exp 0", tag, mem_wr_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic test_bypass();
    for (int a = 0; a < DEPTH; a++) pre_mem[a] = rand_vec();
    load_memory();
    vecs.delete();
    for (int k = 1; k <= 4; k++) vecs.push_back(W'(k));
    run_pass(4'h2, 4, 2'd0, 16'hFFFF, "bypass");
  endtask

  task automatic test_accum();
    logic [W-1:0] h, f;
    for (int l = 0; l < COL; l++) begin
      h[l*PBW +: PBW] = 100;
      f[l*PBW +: PBW] = 5;
    end
    for (int a = 0; a < DEPTH; a++) pre_mem[a] = h;
    load_memory();
    vecs.delete();
    repeat (3) vecs.push_back(f);
    run_pass(4'h8, 3, 2'd1, 16'hFFFF, "accum");
    checks++;
    if (wr_data.size() < 1 || wr_data[0][PBW-1:0] !== 32'd105) begin
      errors++;
      $display("FAIL accum_105 got %h exp 105",
               wr_data.size() ? wr_data[0][PBW-1:0] : 32'hx);
    end
  endtask

  task automatic test_sat_relu();
    for (int a = 0; a < DEPTH; a++) pre_mem[a] = '0;
    pre_mem[5] = W'(32'h20);
    pre_mem[6] = W'(32'd10);
    load_memory();
    vecs.delete();
    vecs.push_back(W'(32'h7FFF_FFF0));
    vecs.push_back(W'(-32'sd50));
    run_pass(4'h5, 2, 2'd2, 16'hFFFF, "sat_relu");
    checks += 3;
    if (wr_data.size() < 2 || wr_data[0][PBW-1:0] !== 32'h7FFF_FFFF) begin
      errors++;
      $display("FAIL sat_clamp got %h exp 7fffffff",
               wr_data.size() ? wr_data[0][PBW-1:0] : 32'hx);
    end
    if (wr_data.size() < 2 || wr_data[1][PBW-1:0] !== 32'h0) begin
      errors++;
      $display("FAIL relu_zero got %h exp 0",
               wr_data.size() > 1 ? wr_data[1][PBW-1:0] : 32'hx);
    end
    if (sat_flag !== 4'b0001) begin
      errors++;
      $display("FAIL sat_flag_lane0 got %b exp 0001", sat_flag);
    end
    vecs.delete();
    vecs.push_back(rand_vec());
    run_pass(4'h9, 1, 2'd3, 16'hFFFF, "sat_cleared");
  endtask

  task automatic test_bubble_wrap();
    for (int a = 0; a < DEPTH; a++) pre_mem[a] = rand_vec();
    load_memory();
    vecs.delete();
    for (int k = 0; k < 4; k++) vecs.push_back(rand_vec());
    run_pass(4'd14, 4, 2'd1, 16'hFFDB, "bubble_wrap");
  endtask

  task automatic test_empty();
    vecs.delete();
    run_pass(4'd3, 0, 2'd1, 16'hFFFF, "empty");
  endtask

  task automatic test_reset_mid();
    for (int a = 0; a < DEPTH; a++) pre_mem[a] = rand_vec();
    load_memory();
    clear_mon();
    for (int k = 0; k < 6; k++) begin
      farr[fwr % 256] = rand_vec();
      fwr++;
    end
    @(posedge clk); #1;
    base_addr = 4'd3; num_vec = 4'd6; mode = 2'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_cyc.size() != 2) begin
      errors++;
      $display("FAIL mid_issued got %0d exp 2", rd_cyc.size());
    end
    check_zero_outputs("reset_mid");
    @(posedge clk); #1; reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks += 2;
    if (wr_addr.size() != 0) begin
      errors++;
      $display("FAIL mid_no_wr got %0d exp 0", wr_addr.size());
    end
    if (done_cyc.size() != 0) begin
      errors++;
      $display("FAIL mid_no_done got %0d exp 0", done_cyc.size());
    end
    vecs.delete();
    for (int k = 0; k < 6; k++) vecs.push_back(rand_vec());
    run_pass(4'd3, 6, 2'd1, 16'hFFFF, "after_reset");
  endtask

  task automatic test_random();
    for (int p = 0; p < 12; p++) begin
      int n = $urandom_range(1, 15);
      for (int a = 0; a < DEPTH; a++) pre_mem[a] = rand_vec();
      load_memory();
      vecs.delete();
      for (int k = 0; k < n; k++) vecs.push_back(rand_vec());
      run_pass(ABW'($urandom), n, 2'($urandom), 16'($urandom) | 16'h0102,
               $sformatf("rand%0d", p));
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_accum();
    test_sat_relu();
    test_bubble_wrap();
    test_empty();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
